// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI transfer sequencer: FSM encoding, default sizes, mode constants.
// No logic; only types, constants and a width helper.
// Imported by the sequencer, its register-side interface and the testbench.
package spi_ctrl_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DIV_W_DEF  = 8;
    localparam int CS_NUM_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // SPI modes encoded as {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // Width of a chip-select index; never zero so a single-slave build still has a port
    function automatic int cs_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Register-file side of the SPI sequencer: configuration, TX data, start strobe and status.
// Pure wiring, zero latency. The start strobe is a single-cycle request with no ready.
// Optional SPI_LOOPBACK_EN adds the i_loopback configuration bit.
interface spi_xfer_ctrl_if #(
    parameter int DATA_W = spi_ctrl_pkg::DATA_W_DEF,
    parameter int DIV_W  = spi_ctrl_pkg::DIV_W_DEF,
    parameter int CS_NUM = spi_ctrl_pkg::CS_NUM_DEF
);
    localparam int CS_W = spi_ctrl_pkg::cs_width(CS_NUM);

    logic              i_start;
    logic              i_cpol;
    logic              i_cpha;
    logic              i_lsb_first;
    logic [DIV_W-1:0]  i_clk_div;
    logic [CS_W-1:0]   i_cs_sel;
    logic [DATA_W-1:0] i_tx_data;
`ifdef SPI_LOOPBACK_EN
    logic              i_loopback;
`endif
    logic              o_busy;
    logic              o_done;
    logic [DATA_W-1:0] o_rx_data;

`ifdef SPI_LOOPBACK_EN
    modport master (output i_start, i_cpol, i_cpha, i_lsb_first, i_clk_div, i_cs_sel, i_tx_data,
                           i_loopback,
                    input  o_busy, o_done, o_rx_data);
    modport slave  (input  i_start, i_cpol, i_cpha, i_lsb_first, i_clk_div, i_cs_sel, i_tx_data,
                           i_loopback,
                    output o_busy, o_done, o_rx_data);
`else
    modport master (output i_start, i_cpol, i_cpha, i_lsb_first, i_clk_div, i_cs_sel, i_tx_data,
                    input  o_busy, o_done, o_rx_data);
    modport slave  (input  i_start, i_cpol, i_cpha, i_lsb_first, i_clk_div, i_cs_sel, i_tx_data,
                    output o_busy, o_done, o_rx_data);
`endif

endinterface

// File: rtl/spi_clk_div.sv
// Half-period tick generator: loadable down-counter that pulses tick when it reaches zero.
// tick is combinational from the count; a reload value of 0 ticks every enabled cycle.
// No backpressure; load has priority over counting.
module spi_clk_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-1:0] reload_val,
    output logic             tick
);
    logic [DIV_W-1:0] cnt;

    assign tick = en && (cnt == '0);

    // Down-count while enabled, reloading on every tick so the period is reload_val+1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= reload_val;
        end else if (en) begin
            cnt <= tick ? reload_val : cnt - 1'b1;
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI master frame sequencer: drives SCLK/MOSI/CS from a shadowed config and captures MISO.
// o_done rises (2*DATA_W+2)*(clk_div+1) cycles after the accepting edge; all outputs registered.
// No queuing: i_start outside IDLE (including the done cycle) is dropped. Option: SPI_LOOPBACK_EN.
module spi_xfer_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIV_W  = DIV_W_DEF,
    parameter int CS_NUM = CS_NUM_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    spi_xfer_ctrl_if.slave    regs,
    input  logic              i_miso,
    output logic              o_sclk,
    output logic              o_mosi,
    output logic [CS_NUM-1:0] o_cs_n
);
    localparam int CS_W   = cs_width(CS_NUM);
    localparam int EDGE_W = $clog2(2 * DATA_W);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    state_t            state, state_nxt;
    logic              cpol_q, cpha_q, lsb_q;
    logic [DIV_W-1:0]  div_q;
    logic [DATA_W-1:0] tx_sr, rx_sr;
    logic [EDGE_W-1:0] edge_cnt;
    logic              tick, accept, toggle, shift_out, sample, finish, leading;
    logic              miso_src;

    // Head bit and shift of the TX shadow, honouring bit order
    function automatic logic head_bit(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_once(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    // Active-low select for an index; out-of-range indexes select nobody
    function automatic logic [CS_NUM-1:0] cs_active(input logic [CS_W-1:0] sel);
        logic [CS_NUM-1:0] oh;
        oh = '0;
        for (int i = 0; i < CS_NUM; i++) begin
            if (sel == CS_W'(i)) oh[i] = 1'b1;
        end
        return ~oh;
    endfunction

`ifdef SPI_LOOPBACK_EN
    logic loop_q;
    assign miso_src = loop_q ? o_mosi : i_miso;
`else
    assign miso_src = i_miso;
`endif

    spi_clk_div #(.DIV_W(DIV_W)) u_clk_div (
        .clk        (i_clk),
        .rst        (i_rst),
        .en         (state != ST_IDLE),
        .load       (accept),
        .reload_val (accept ? regs.i_clk_div : div_q),
        .tick       (tick)
    );

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state plus per-cycle strobes for the datapath; odd ticks (even edge_cnt) are leading edges
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        toggle    = 1'b0;
        shift_out = 1'b0;
        sample    = 1'b0;
        finish    = 1'b0;
        leading   = (edge_cnt[0] == 1'b0);
        case (state)
            ST_IDLE: begin
                if (regs.i_start) begin
                    accept    = 1'b1;
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tick) state_nxt = ST_XFER;
            end
            ST_XFER: begin
                if (tick) begin
                    toggle = 1'b1;
                    if (leading) begin
                        sample    = !cpha_q;
                        shift_out = cpha_q;
                    end else begin
                        sample    = cpha_q;
                        shift_out = !cpha_q && (edge_cnt != LAST_EDGE);
                    end
                    if (edge_cnt == LAST_EDGE) state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // The done cycle still belongs to the frame, so IDLE is entered one cycle later
                if (regs.o_done)  state_nxt = ST_IDLE;
                else if (tick)    finish    = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Shadow config, shift registers, pin drivers and status
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cpol_q         <= 1'b0;
            cpha_q         <= 1'b0;
            lsb_q          <= 1'b0;
            div_q          <= '0;
            tx_sr          <= '0;
            rx_sr          <= '0;
            edge_cnt       <= '0;
            o_sclk         <= 1'b0;
            o_mosi         <= 1'b0;
            o_cs_n         <= '1;
            regs.o_busy    <= 1'b0;
            regs.o_done    <= 1'b0;
            regs.o_rx_data <= '0;
`ifdef SPI_LOOPBACK_EN
            loop_q         <= 1'b0;
`endif
        end else begin
            regs.o_done <= 1'b0;
            if (accept) begin
                cpol_q      <= regs.i_cpol;
                cpha_q      <= regs.i_cpha;
                lsb_q       <= regs.i_lsb_first;
                div_q       <= regs.i_clk_div;
                rx_sr       <= '0;
                o_sclk      <= regs.i_cpol;
                regs.o_busy <= 1'b1;
`ifdef SPI_LOOPBACK_EN
                loop_q      <= regs.i_loopback;
                o_cs_n      <= regs.i_loopback ? '1 : cs_active(regs.i_cs_sel);
`else
                o_cs_n      <= cs_active(regs.i_cs_sel);
`endif
                // cpha=0 must present the first bit before the first leading edge
                if (!regs.i_cpha) begin
                    o_mosi <= head_bit(regs.i_tx_data, regs.i_lsb_first);
                    tx_sr  <= shift_once(regs.i_tx_data, regs.i_lsb_first);
                end else begin
                    tx_sr  <= regs.i_tx_data;
                end
            end
            if (state == ST_SETUP) edge_cnt <= '0;
            if (toggle) begin
                o_sclk   <= ~o_sclk;
                edge_cnt <= edge_cnt + 1'b1;
            end
            if (shift_out) begin
                o_mosi <= head_bit(tx_sr, lsb_q);
                tx_sr  <= shift_once(tx_sr, lsb_q);
            end
            if (sample) begin
                rx_sr <= lsb_q ? {miso_src, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], miso_src};
            end
            if (finish) begin
                o_sclk         <= cpol_q;
                o_cs_n         <= '1;
                regs.o_rx_data <= rx_sr;
                regs.o_done    <= 1'b1;
                regs.o_busy    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl acting as register file and SPI slave.
// Expected MOSI word, RX word, chip-select pattern and done latency come from the frame parameters.
// Build with +define+SPI_LOOPBACK_EN to include the loopback frame.
module tb_spi_xfer_ctrl;
    import spi_ctrl_pkg::*;

    localparam int DATA_W = 8;
    localparam int DIV_W  = 8;
    localparam int CS_NUM = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              miso;
    logic              sclk;
    logic              mosi;
    logic [CS_NUM-1:0] cs_n;

    int n_vec = 0;
    int n_err = 0;
    int fid   = 0;

    spi_xfer_ctrl_if #(.DATA_W(DATA_W), .DIV_W(DIV_W), .CS_NUM(CS_NUM)) regs ();

    spi_xfer_ctrl #(.DATA_W(DATA_W), .DIV_W(DIV_W), .CS_NUM(CS_NUM)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .regs   (regs),
        .i_miso (miso),
        .o_sclk (sclk),
        .o_mosi (mosi),
        .o_cs_n (cs_n)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic bit_at(input logic [7:0] w, input int i, input logic lsb);
        return lsb ? w[i] : w[7 - i];
    endfunction

    // One frame seen from the slave side. mode: 0 plain, 1 extra start at cycle 5,
    // 2 registers changed mid-frame, 3 start in the done cycle, 4 start one cycle after done.
    task automatic run_frame(input logic cpol, input logic cpha, input logic lsb,
                             input logic [7:0] div, input logic [1:0] sel,
                             input logic [7:0] tx, input logic [7:0] mw,
                             input logic lb, input int mode);
        int lat, done_n, done_cnt, edges, mi, ci;
        logic prev_sclk, cs_bad, busy_bad, capture, sclk_end, busy_end;
        logic [3:0] cs_end, exp_cs;
        logic [7:0] mosi_w, exp_rx;
        string p;
        fid++;
        p      = $sformatf("f%0d_", fid);
        lat    = (2 * DATA_W + 2) * (int'(div) + 1) + 1;
        exp_rx = lb ? tx : mw;
        exp_cs = lb ? 4'hF : (4'hF ^ (4'h1 << sel));
        @(negedge clk);
        regs.i_cpol      = cpol;
        regs.i_cpha      = cpha;
        regs.i_lsb_first = lsb;
        regs.i_clk_div   = div;
        regs.i_cs_sel    = sel;
        regs.i_tx_data   = tx;
`ifdef SPI_LOOPBACK_EN
        regs.i_loopback  = lb;
`endif
        regs.i_start = 1'b1;
        miso = 1'b0;
        mi = 0; ci = 0; mosi_w = '0;
        if (!cpha && !lb) begin
            miso = bit_at(mw, 0, lsb);
            mi = 1;
        end
        prev_sclk = cpol; done_n = 0; done_cnt = 0; edges = 0;
        cs_bad = 1'b0; busy_bad = 1'b0; sclk_end = 1'bx; busy_end = 1'bx; cs_end = 'x;
        for (int n = 1; n <= lat + 3; n++) begin
            @(negedge clk);
            if (n == 1) regs.i_start = 1'b0;
            if (n < lat && sclk !== prev_sclk) begin
                edges++;
                capture = (sclk != cpol) ^ cpha;
                if (capture) begin
                    if (ci < 8) mosi_w[lsb ? ci : 7 - ci] = mosi;
                    ci++;
                end else if (mi < 8 && !lb) begin
                    miso = bit_at(mw, mi, lsb);
                    mi++;
                end
            end
            prev_sclk = sclk;
            if (n < lat) begin
                if (cs_n !== exp_cs)      cs_bad   = 1'b1;
                if (regs.o_busy !== 1'b1) busy_bad = 1'b1;
            end
            if (n == lat) begin
                sclk_end = sclk;
                busy_end = regs.o_busy;
                cs_end   = cs_n;
            end
            if (regs.o_done === 1'b1) begin
                done_cnt++;
                if (done_n == 0) done_n = n;
            end
            if (mode == 1 && n == 5) regs.i_start = 1'b1;
            if (mode == 1 && n == 6) regs.i_start = 1'b0;
            if (mode == 2 && n == 3) begin
                regs.i_tx_data   = ~tx;
                regs.i_clk_div   = div + 8'd3;
                regs.i_lsb_first = ~lsb;
                regs.i_cs_sel    = sel + 2'd1;
            end
            if (mode == 3) begin
                if (n == lat + 2) check_val({p, "start_in_done_cycle_ignored"}, regs.o_busy, 0);
                if (n == lat)     regs.i_start = 1'b1;
                if (n == lat + 1) regs.i_start = 1'b0;
            end
            if (mode == 4) begin
                if (n == lat + 2) begin
                    check_val({p, "start_after_done_accepted"}, regs.o_busy, 1);
                    regs.i_start = 1'b0;
                end
                if (n == lat + 1) regs.i_start = 1'b1;
            end
        end
        check_val({p, "done_latency"}, done_n, lat);
        check_val({p, "done_count"}, done_cnt, 1);
        check_val({p, "rx_data"}, regs.o_rx_data, exp_rx);
        check_val({p, "mosi_word"}, mosi_w, tx);
        check_val({p, "sclk_edges"}, edges, 2 * DATA_W);
        check_val({p, "cs_during_frame_bad"}, cs_bad, 0);
        check_val({p, "busy_during_frame_bad"}, busy_bad, 0);
        check_val({p, "cs_after_done"}, cs_end, 4'hF);
        check_val({p, "busy_after_done"}, busy_end, 0);
        check_val({p, "sclk_idle_level"}, sclk_end, cpol);
    endtask

    // Wait for a frame started elsewhere to complete, bounded
    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 500 && !seen; n++) begin
            @(negedge clk);
            if (regs.o_done === 1'b1) seen = 1'b1;
        end
        check_val(tag, seen, 1);
    endtask

    // Abort a mode-3 frame with reset right after the 7th SCLK toggle
    task automatic reset_mid_frame();
        int edges, spurious;
        logic prev, hit;
        @(negedge clk);
        regs.i_cpol = 1'b1; regs.i_cpha = 1'b1; regs.i_lsb_first = 1'b0;
        regs.i_clk_div = 8'd1; regs.i_cs_sel = 2'd1; regs.i_tx_data = 8'hF0;
`ifdef SPI_LOOPBACK_EN
        regs.i_loopback = 1'b0;
`endif
        regs.i_start = 1'b1;
        miso = 1'b1;
        prev = 1'b1; edges = 0; hit = 1'b0;
        for (int n = 1; n <= 200 && !hit; n++) begin
            @(negedge clk);
            if (n == 1) regs.i_start = 1'b0;
            if (sclk !== prev) begin
                edges++;
                prev = sclk;
            end
            if (edges == 7) begin
                rst = 1'b1;
                #1;
                check_val("rst_cs_n", cs_n, 4'hF);
                check_val("rst_sclk", sclk, 0);
                check_val("rst_mosi", mosi, 0);
                check_val("rst_busy", regs.o_busy, 0);
                check_val("rst_done", regs.o_done, 0);
                check_val("rst_rx_data", regs.o_rx_data, 0);
                hit = 1'b1;
            end
        end
        check_val("rst_reached_tick7", hit, 1);
        @(negedge clk);
        rst = 1'b0;
        spurious = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (regs.o_done === 1'b1) spurious++;
        end
        check_val("no_done_after_rst", spurious, 0);
        check_val("sclk_idle_after_rst", sclk, 0);
    endtask

    initial begin
        logic [7:0] r_tx, r_mw, r_div;
        logic [1:0] r_sel;
        logic       r_pol, r_pha, r_lsb;
        int         r_mode;
        rst = 1'b1;
        miso = 1'b0;
        regs.i_start = 1'b0; regs.i_cpol = 1'b0; regs.i_cpha = 1'b0; regs.i_lsb_first = 1'b0;
        regs.i_clk_div = '0; regs.i_cs_sel = '0; regs.i_tx_data = '0;
`ifdef SPI_LOOPBACK_EN
        regs.i_loopback = 1'b0;
`endif
        #1;
        check_val("reset_sclk", sclk, 0);
        check_val("reset_mosi", mosi, 0);
        check_val("reset_cs_n", cs_n, 4'hF);
        check_val("reset_busy", regs.o_busy, 0);
        check_val("reset_done", regs.o_done, 0);
        check_val("reset_rx_data", regs.o_rx_data, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Mode 0, div 1, MSB-first: latency 37
        run_frame(SPI_MODE0[1], SPI_MODE0[0], 1'b0, 8'd1, 2'd0, 8'hA5, 8'h3C, 1'b0, 0);
        // Mode 3, div 0, LSB-first, slave 2: latency 19
        run_frame(SPI_MODE3[1], SPI_MODE3[0], 1'b1, 8'd0, 2'd2, 8'h81, 8'h5A, 1'b0, 0);
        // Extra start mid-frame
        run_frame(SPI_MODE1[1], SPI_MODE1[0], 1'b0, 8'd2, 2'd1, 8'h6E, 8'hB1, 1'b0, 1);
        // Registers changed mid-frame
        run_frame(SPI_MODE2[1], SPI_MODE2[0], 1'b1, 8'd1, 2'd3, 8'h37, 8'hC8, 1'b0, 2);
        // Back-to-back starts around done
        run_frame(SPI_MODE0[1], SPI_MODE0[0], 1'b0, 8'd0, 2'd0, 8'h1F, 8'hE2, 1'b0, 3);
        run_frame(SPI_MODE0[1], SPI_MODE0[0], 1'b0, 8'd0, 2'd1, 8'h99, 8'h42, 1'b0, 4);
        wait_done("b2b_frame_done");
        // Reset mid-frame, then a normal frame
        reset_mid_frame();
        run_frame(SPI_MODE1[1], SPI_MODE1[0], 1'b1, 8'd2, 2'd2, 8'hD4, 8'h2B, 1'b0, 0);
`ifdef SPI_LOOPBACK_EN
        run_frame(SPI_MODE0[1], SPI_MODE0[0], 1'b0, 8'd1, 2'd1, 8'hC3, 8'h00, 1'b1, 0);
`endif
        // Randomized frames
        for (int k = 0; k < 10; k++) begin
            r_tx   = 8'($urandom);
            r_mw   = 8'($urandom);
            r_div  = 8'($urandom_range(0, 3));
            r_sel  = 2'($urandom_range(0, 3));
            r_pol  = 1'($urandom_range(0, 1));
            r_pha  = 1'($urandom_range(0, 1));
            r_lsb  = 1'($urandom_range(0, 1));
            r_mode = ($urandom_range(0, 1) == 1) ? 2 : 0;
            run_frame(r_pol, r_pha, r_lsb, r_div, r_sel, r_tx, r_mw, 1'b0, r_mode);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
        $fatal(1);
    end

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
- SPI master transfer sequencer behind the APB register block.
- Takes configuration and TX data from the register file, plus a one-cycle start strobe from a CTRL register write.
- Generates SCLK, MOSI and chip selects, and captures MISO.
- Returns RX data, busy and done status to the register file. Done feeds the STATUS register and the interrupt logic.

Parameters:
- DATA_W, 8, bits per frame (legal 4..32)
- DIV_W, 8, width of clock divider field
- CS_NUM, 4, number of chip-select outputs (power of 2, max 16)

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-high reset
- i_start  in  1  start pulse from CTRL register write
- i_cpol  in  1  SCLK idle level
- i_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- i_lsb_first  in  1  bit order
- i_clk_div  in  DIV_W  SCLK half-period = i_clk_div+1 i_clk cycles
- i_cs_sel  in  $clog2(CS_NUM)  target slave index
- i_tx_data  in  DATA_W  frame to transmit
- i_miso  in  1  serial input
- o_sclk  out  1  SPI clock
- o_mosi  out  1  serial output
- o_cs_n  out  CS_NUM  active-low chip selects, one-hot-low when active
- o_busy  out  1  high from the cycle after start acceptance until done
- o_done  out  1  one-cycle pulse at end of frame
- o_rx_data  out  DATA_W  last received frame; held until the next frame completes

Behaviour:
- Reset values: o_sclk=0, o_mosi=0, o_cs_n=all ones, o_busy=0, o_done=0, o_rx_data=0, state IDLE, internal latched cpol=0.
- Start acceptance:
  - i_start is accepted only in IDLE.
  - In any other state it is ignored, with no queuing.
  - On acceptance, latch cpol, cpha, lsb_first, clk_div, cs_sel and tx_data into a shadow set. Register changes mid-frame have no effect.
- Half-period tick: counter reloads to the latched clk_div and pulses tick when it reaches 0. clk_div=0 gives a tick every cycle.
- States:
  - IDLE:
    - o_sclk = latched cpol; o_cs_n all ones.
    - On accept -> SETUP, counter loaded.
  - SETUP:
    - Selected o_cs_n low.
    - If cpha=0, o_mosi = first bit.
    - Lasts one half-period, then -> XFER.
  - XFER:
    - 2*DATA_W ticks; each tick toggles o_sclk.
    - Odd ticks are leading edges, even ticks are trailing edges.
    - cpha=0: sample i_miso on leading edge; shift out the next bit on trailing edge (except the last trailing edge).
    - cpha=1: shift out on leading edge; sample on trailing edge.
    - After the final tick -> HOLD.
  - HOLD:
    - o_sclk at cpol, CS held low.
    - Lasts one half-period.
    - On exit: o_cs_n all ones, o_rx_data updated, o_done=1 for one cycle, o_busy=0, -> IDLE.
- Bit order: lsb_first=0 sends tx[DATA_W-1] first and assembles rx MSB-first. lsb_first=1 is the mirror.
- Latency: o_done is high exactly (2*DATA_W+2)*(clk_div+1)+1 cycles after the edge that samples i_start.
- Back-to-back: a start on the same cycle as o_done is ignored, because the FSM is not yet in IDLE. A start one cycle later is accepted.
- i_cs_sel >= CS_NUM cannot occur (width-limited). With CS_NUM not a power of 2, out-of-range selects assert no CS, but the transfer still runs.
- Reset mid-frame: all outputs return to reset values immediately (async), the frame is abandoned, and no done pulse is produced.

Optional Feature:
- Macro SPI_LOOPBACK_EN.
- When defined: adds input i_loopback (1 bit, latched at start). When the latched value is 1, the sampler uses internal o_mosi instead of i_miso, o_cs_n stays all ones, and SCLK/MOSI still toggle.
- When undefined: the port is absent and the sampler always uses i_miso.

Decomposition:
- Package spi_ctrl_pkg: state encoding (IDLE, SETUP, XFER, HOLD), DATA_W/DIV_W/CS_NUM defaults, SPI mode constants.
- Sub-module spi_clk_div: loadable down-counter producing the half-period tick, with enable and reload inputs.

Test Plan:
- Mode 0 (cpol=0, cpha=0), div=1, tx=0xA5, MSB-first; bench drives MISO pattern 0x3C on leading edges -> MOSI bits 1,0,1,0,0,1,0,1; rx=0x3C; o_done 37 cycles after start; o_cs_n[0] low for the whole frame.
- Mode 3 (cpol=1, cpha=1), div=0, tx=0x81, lsb_first=1, cs_sel=2 -> SCLK idles high; only o_cs_n[2] low; MISO 0x5A sampled on trailing edges gives rx=0x5A; done at cycle 19.
- Second i_start pulse at cycle 5 of an active frame -> ignored; exactly one done pulse; a start one cycle after done begins a new frame.
- Change i_tx_data and i_clk_div mid-frame -> transmitted bits and timing unchanged from the latched values.
- Assert i_rst at XFER tick 7 -> o_cs_n all ones and o_sclk=0 in the same cycle; o_busy=0; no o_done; the next start completes normally.
- With SPI_LOOPBACK_EN and i_loopback=1, tx=0xC3 -> rx=0xC3 with i_miso tied to 0; o_cs_n stays all ones.
